// File: rtl/reduction_scheduler_pkg.sv
// Shared NPU definitions used by the reduction scheduler: data width, reduction op codes,
// scheduler state encoding and the default watchdog limit.
package reduction_scheduler_pkg;

    localparam int unsigned NPU_DATA_WIDTH      = 16;
    localparam int unsigned RED_TIMEOUT_DEFAULT = 64;

    localparam logic [2:0] RED_SUM  = 3'd0;
    localparam logic [2:0] RED_MAX  = 3'd1;
    localparam logic [2:0] RED_MIN  = 3'd2;
    localparam logic [2:0] RED_MEAN = 3'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr_i,
// wrapping modulo N, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    int unsigned cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = 32'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!valid_o && cand < N && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/reduction_scheduler.sv
// Time-shares one reduction unit between NUM_REQ requesters: round-robin grant, latched
// operand, unit handshakes, watchdog abort and result routing back to the winner.
module reduction_scheduler
    import reduction_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned NUM_LANES  = 16,
    parameter int unsigned DATA_WIDTH = NPU_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = RED_TIMEOUT_DEFAULT,
    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned VecW = NUM_LANES * DATA_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*VecW-1:0]       req_data_i,
    input  logic [NUM_REQ*3-1:0]          req_type_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    output logic [VecW-1:0]               ru_data_o,
    output logic [2:0]                    ru_type_o,
    output logic                          ru_valid_o,
    input  logic                          ru_ready_i,
    input  logic [DATA_WIDTH-1:0]         ru_result_i,
    input  logic                          ru_result_valid_i,
    output logic                          ru_result_ready_o,
    output logic                          busy_o,
    output logic [IdxW-1:0]               grant_id_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_e          state_q;
    logic [IdxW-1:0]       ptr_q, gidx_q, ptr_d;
    logic [VecW-1:0]       vec_q;
    logic [2:0]            type_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_err_q, ru_valid_q, ru_rready_q;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [IdxW-1:0]       arb_idx;
    logic                  arb_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Explicit wrap so non-power-of-two requester counts stay in range.
    assign ptr_d = (arb_idx == IdxW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gidx_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            ru_valid_q  <= 1'b0;
            ru_rready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ru_rready_q <= 1'b1;
                    if (arb_valid) begin
                        state_q     <= StIssue;
                        gidx_q      <= arb_idx;
                        ptr_q       <= ptr_d;
                        vec_q       <= req_data_i[VecW*arb_idx +: VecW];
                        type_q      <= req_type_i[3*arb_idx +: 3];
                        ru_valid_q  <= 1'b1;
                        ru_rready_q <= 1'b0;
                    end
                end
                StIssue: begin
                    if (ru_ready_i) begin
                        state_q     <= StWait;
                        cnt_q       <= '0;
                        ru_valid_q  <= 1'b0;
                        ru_rready_q <= 1'b1;
                    end
                end
                StWait: begin
                    // A result arriving on the last watchdog cycle takes priority over the abort.
                    if (ru_result_valid_i) begin
                        state_q     <= StResp;
                        rsp_data_q  <= ru_result_i;
                        rsp_err_q   <= 1'b0;
                        ru_rready_q <= 1'b0;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q     <= StResp;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        ru_rready_q <= 1'b0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i[gidx_q]) begin
                        state_q     <= StIdle;
                        ru_rready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == StResp) begin
            rsp_valid_o[gidx_q] = 1'b1;
        end
    end

    assign req_ready_o       = (state_q == StIdle) ? arb_gnt : '0;
    assign rsp_data_o        = rsp_data_q;
    assign rsp_err_o         = rsp_err_q;
    assign ru_data_o         = vec_q;
    assign ru_type_o         = type_q;
    assign ru_valid_o        = ru_valid_q;
    assign ru_result_ready_o = ru_rready_q;
    assign busy_o            = (state_q != StIdle);
    assign grant_id_o        = gidx_q;

endmodule

// File: tb/tb_reduction_scheduler.sv
// Directed bench for reduction_scheduler: table of single transactions against a behavioural
// reduction unit, plus fairness, backpressure and mid-transaction reset sequences.
module tb_reduction_scheduler;
    import reduction_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int NL = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NR-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NR*NL*DW-1:0] req_data;
    logic [NR*3-1:0]     req_type;
    logic [DW-1:0]       rsp_data;
    logic                rsp_err;
    logic [NL*DW-1:0]    ru_data;
    logic [2:0]          ru_type;
    logic                ru_valid, ru_ready;
    logic [DW-1:0]       ru_result;
    logic                ru_result_valid, ru_result_ready, busy;
    logic [1:0]          grant_id;

    reduction_scheduler #(
        .NUM_REQ    (NR),
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_data_i        (req_data),
        .req_type_i        (req_type),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_data_o        (rsp_data),
        .rsp_err_o         (rsp_err),
        .ru_data_o         (ru_data),
        .ru_type_o         (ru_type),
        .ru_valid_o        (ru_valid),
        .ru_ready_i        (ru_ready),
        .ru_result_i       (ru_result),
        .ru_result_valid_i (ru_result_valid),
        .ru_result_ready_o (ru_result_ready),
        .busy_o            (busy),
        .grant_id_o        (grant_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         rq;
        logic [2:0] ty;
        int         base;
        int         stp;
        int         delay;      // WAIT cycle carrying the result; -1 means never
        int         force_res;  // -1 means the unit computes the reduction
        logic [15:0] exp_data;
        logic       exp_err;
        int         exp_gap;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic load_req(input int rq, input logic [2:0] ty, input int base, input int stp);
        for (int i = 0; i < NL; i++) begin
            req_data[(rq*NL+i)*DW +: DW] = DW'(base + i*stp);
        end
        req_type[rq*3 +: 3] = ty;
    endtask

    // Behavioural reduction unit.
    function automatic logic [DW-1:0] reduce(input logic [NL*DW-1:0] v, input logic [2:0] ty);
        int unsigned sum;
        logic [DW-1:0] mx, mn, e;
        sum = 0;
        mx  = '0;
        mn  = '1;
        for (int i = 0; i < NL; i++) begin
            e   = v[i*DW +: DW];
            sum = sum + e;
            if (e > mx) mx = e;
            if (e < mn) mn = e;
        end
        case (ty)
            RED_SUM:  return DW'(sum);
            RED_MAX:  return mx;
            RED_MIN:  return mn;
            default:  return DW'(sum / NL);
        endcase
    endfunction

    // Runs one transaction from an IDLE cycle with the request inputs already driven.
    task automatic do_txn(input int rq, input bit drop, input int delay, input int force_res,
                          input logic [DW-1:0] exp_data, input logic exp_err, input int exp_gap,
                          input logic [2:0] exp_ty);
        int gap;
        bit got;
        logic [DW-1:0] res;
        #1;
        check("grant req_ready", 32'(req_ready), 32'(onehot(rq)));
        step();
        gap = 1;
        if (drop) req_valid = '0;
        #1;
        check("issue ru_valid", 32'(ru_valid), 32'd1);
        check("issue ru_type", 32'(ru_type), 32'(exp_ty));
        check("issue grant_id", 32'(grant_id), 32'(rq));
        check("issue req_ready", 32'(req_ready), 32'd0);
        res = (force_res >= 0) ? DW'(force_res) : reduce(ru_data, ru_type);
        ru_ready = 1'b1;
        step();
        gap++;
        ru_ready = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (k == 0) check("wait ru_result_ready", 32'(ru_result_ready), 32'd1);
            if (k == delay) begin
                ru_result_valid = 1'b1;
                ru_result       = res;
            end
            step();
            gap++;
            ru_result_valid = 1'b0;
            if (rsp_valid != '0) got = 1'b1;
        end
        check("rsp_valid seen", 32'(got), 32'd1);
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(rq)));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("grant-to-rsp gap", 32'(gap), 32'(exp_gap));
        check("resp req_ready", 32'(req_ready), 32'd0);
        rsp_ready = onehot(rq);
        step();
        rsp_ready = '0;
        check("done busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_data = '0; req_type = '0; rsp_ready = '0;
        ru_ready = 1'b0; ru_result = '0; ru_result_valid = 1'b0;
        rst = 1'b1;
        step();
        do_reset();
        check("reset busy", 32'(busy), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset ru_valid", 32'(ru_valid), 32'd0);
        check("reset ru_result_ready", 32'(ru_result_ready), 32'd0);
        check("reset grant_id", 32'(grant_id), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        check("reset rsp_data", 32'(rsp_data), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);

        //          rq  ty        base stp delay force  exp      err  gap
        tbl[0] = '{1, RED_SUM,  1,   1,  0,   -1,  16'd136, 1'b0, 3};
        tbl[1] = '{3, RED_MAX,  100, 1,  1,   -1,  16'd115, 1'b0, 4};
        tbl[2] = '{0, RED_MIN,  200, -3, 0,   -1,  16'd155, 1'b0, 3};
        tbl[3] = '{2, RED_MEAN, 1,   1,  2,   -1,  16'd8,   1'b0, 5};
        tbl[4] = '{1, RED_SUM,  0,   0,  -1,  -1,  16'd0,   1'b1, 10};
        tbl[5] = '{1, RED_SUM,  10,  2,  0,   -1,  16'd400, 1'b0, 3};
        tbl[6] = '{0, RED_MAX,  3,   1,  7,   'h55, 16'h55, 1'b0, 10};
        tbl[7] = '{3, RED_MIN,  5,   1,  6,   -1,  16'd5,   1'b0, 9};

        for (int t = 0; t < 8; t++) begin
            load_req(tbl[t].rq, tbl[t].ty, tbl[t].base, tbl[t].stp);
            req_valid = onehot(tbl[t].rq);
            do_txn(tbl[t].rq, 1'b1, tbl[t].delay, tbl[t].force_res, tbl[t].exp_data,
                   tbl[t].exp_err, tbl[t].exp_gap, tbl[t].ty);
        end

        // Fairness: all requesters held valid from pointer 0.
        do_reset();
        for (int r = 0; r < NR; r++) load_req(r, RED_SUM, r*16 + 1, 1);
        req_valid = '1;
        do_txn(0, 1'b0, 0, -1, 16'd136, 1'b0, 3, RED_SUM);
        do_txn(1, 1'b0, 0, -1, 16'd392, 1'b0, 3, RED_SUM);
        do_txn(2, 1'b0, 0, -1, 16'd648, 1'b0, 3, RED_SUM);
        do_txn(3, 1'b0, 0, -1, 16'd904, 1'b0, 3, RED_SUM);
        do_txn(0, 1'b1, 0, -1, 16'd136, 1'b0, 3, RED_SUM);

        // Backpressure on both the unit input and the response.
        load_req(2, RED_MAX, 7, 3);
        req_valid = onehot(2);
        #1;
        check("bp req_ready", 32'(req_ready), 32'(onehot(2)));
        step();
        req_valid = '0;
        for (int j = 0; j < 5; j++) begin
            check("bp ru_valid", 32'(ru_valid), 32'd1);
            check("bp ru_type", 32'(ru_type), 32'(RED_MAX));
            check("bp lane0", 32'(ru_data[0 +: DW]), 32'd7);
            check("bp lane15", 32'(ru_data[15*DW +: DW]), 32'd52);
            step();
        end
        ru_ready = 1'b1;
        step();
        ru_ready = 1'b0;
        ru_result_valid = 1'b1;
        ru_result = reduce(ru_data, ru_type);
        step();
        ru_result_valid = 1'b0;
        rsp_ready = 4'b1011;
        for (int j = 0; j < 5; j++) begin
            check("bp rsp_valid", 32'(rsp_valid), 32'(onehot(2)));
            check("bp rsp_data", 32'(rsp_data), 32'd52);
            if (j < 4) step();
        end
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        check("bp done busy", 32'(busy), 32'd0);
        check("bp done rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset while waiting on the unit, then a stale result must be drained silently.
        load_req(1, RED_SUM, 2, 0);
        load_req(3, RED_MAX, 9, 0);
        req_valid = onehot(1);
        #1;
        check("rw req_ready", 32'(req_ready), 32'(onehot(1)));
        step();
        req_valid = '0;
        ru_ready = 1'b1;
        step();
        ru_ready = 1'b0;
        step();
        do_reset();
        check("rw busy", 32'(busy), 32'd0);
        check("rw rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw ru_valid", 32'(ru_valid), 32'd0);
        check("rw grant_id", 32'(grant_id), 32'd0);
        ru_result_valid = 1'b1;
        ru_result = 16'h77;
        step();
        check("stale ru_result_ready", 32'(ru_result_ready), 32'd1);
        check("stale rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        ru_result_valid = 1'b0;
        check("stale rsp_valid later", 32'(rsp_valid), 32'd0);
        check("stale busy", 32'(busy), 32'd0);
        // Pointer back at 0 picks requester 1 over 3.
        req_valid = 4'b1010;
        do_txn(1, 1'b1, 0, -1, 16'd32, 1'b0, 3, RED_SUM);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
